// File: rtl/tsbus_pkg.sv
// Shared types, default widths and helpers for the tri-state bus arbiter.
package tsbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Largest supported requester count; one-hot helper is sized for it.
    localparam int N_MAX      = 16;
    localparam int IDX_W_MAX  = 4;

    // Default parameterisation and the counter widths it implies.
    localparam int DEF_N           = 4;
    localparam int DEF_MAX_HOLD    = 4;
    localparam int DEF_TURN_CYCLES = 1;
    localparam int DEF_OWNER_W     = $clog2(DEF_N);
    localparam int DEF_HOLD_W      = $clog2(DEF_MAX_HOLD + 1);
    localparam int DEF_TURN_W      = $clog2(DEF_TURN_CYCLES + 1);

    // One-hot vector with bit idx set; callers keep the low N bits.
    function automatic logic [N_MAX-1:0] onehot(input logic [IDX_W_MAX-1:0] idx);
        return N_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_pick.sv
// Round-robin search: first set request at or above ptr, wrapping mod N.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    localparam int SW = PTR_W + 1;

    logic [N-1:0]     rot;
    logic [PTR_W-1:0] k;
    logic [SW-1:0]    idx_sum;

    // Rotate so that the pointer position lands at bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [SW-1:0]    sum;
            logic [PTR_W-1:0] pos;
            assign sum    = {1'b0, ptr} + SW'(gi);
            assign pos    = (sum >= SW'(N)) ? PTR_W'(sum - SW'(N)) : PTR_W'(sum);
            assign rot[gi] = req[pos];
        end
    endgenerate

    // Lowest set bit of the rotated vector, then undo the rotation.
    always_comb begin
        found = 1'b0;
        k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                k     = PTR_W'(i);
            end
        end
        idx_sum = {1'b0, ptr} + {1'b0, k};
        idx     = (idx_sum >= SW'(N)) ? PTR_W'(idx_sum - SW'(N)) : PTR_W'(idx_sum);
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared bufif1 bus with tenure limit
// and an all-off turnaround gap between owners.
module tristate_bus_arbiter
    import tsbus_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 bus_busy
);

    localparam int OWNER_W = $clog2(N);
    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam int TURN_W  = $clog2(TURN_CYCLES + 1);

    state_t               state_reg,  state_next;
    logic [N-1:0]         grant_reg,  grant_next;
    logic [OWNER_W-1:0]   owner_reg,  owner_next;
    logic [OWNER_W-1:0]   ptr_reg,    ptr_next;
    logic [HOLD_W-1:0]    hold_reg,   hold_next;
    logic [TURN_W-1:0]    turn_reg,   turn_next;

    logic                 pick_found;
    logic [OWNER_W-1:0]   pick_idx;
    logic [N_MAX-1:0]     pick_oh;

    rr_priority_pick #(
        .N     (N),
        .PTR_W (OWNER_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_oh  = onehot(IDX_W_MAX'(pick_idx));
    assign grant    = grant_reg;
    assign owner    = owner_reg;
    assign bus_busy = |grant_reg;

    // State and output registers; reset drops every driver to high-Z at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
            hold_reg  <= '0;
            turn_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
            turn_reg  <= turn_next;
        end
    end

    // Next-state logic: arbitrate in IDLE/end of TURN, enforce tenure in GRANT.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        turn_next  = turn_reg;

        unique case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_oh[N-1:0];
                    owner_next = pick_idx;
                    hold_next  = HOLD_W'(1);
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (req[owner_reg] && (hold_reg < HOLD_W'(MAX_HOLD))) begin
                    hold_next = hold_reg + HOLD_W'(1);
                end else begin
                    // Drop-out and tenure expiry on the same cycle is one release.
                    grant_next = '0;
                    ptr_next   = (owner_reg == OWNER_W'(N - 1)) ? '0
                                                                : owner_reg + OWNER_W'(1);
                    turn_next  = TURN_W'(1);
                    state_next = TURN;
                end
            end
            TURN: begin
                if (turn_reg >= TURN_W'(TURN_CYCLES)) begin
                    if (pick_found) begin
                        grant_next = pick_oh[N-1:0];
                        owner_next = pick_idx;
                        hold_next  = HOLD_W'(1);
                        state_next = GRANT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    turn_next = turn_reg + TURN_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

endmodule
